chan_readout_sched: RTL and testbench

Per-event readout scheduler for the multi-channel digitizer. It detects the EOS trigger and applies a programmable trigger delay, then freezes the enabled channel buffers. It drains each frozen channel one sample at a time over a valid/ready stream toward the ZYNQ, prefixing the event with a header word, and releases the channels when done. It sits between the per-channel circular buffers and the ZYNQ transfer logic, taking over the trigger, channel-select and read-request sequencing for the channel array.

---
 rtl/chan_readout_sched.sv | 189 ++++++++++++++++++
 tb/tb_chan_readout_sched.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_readout_sched.sv
// chan_readout_sched: per-event readout scheduler for the multi-channel digitizer.
// Detects the EOS rising edge and waits out the trigger delay. It then freezes the
// enabled channels and streams a header word followed by every frozen channel's
// samples (lowest channel first) over a valid/ready port.
module chan_readout_sched #(
    parameter int CHAN       = 8,
    parameter int ADC_WIDTH  = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                      SYSCLK,
    input  logic                      RST,
    input  logic                      EOS,
    input  logic [CHAN-1:0]           chan_mask,
    input  logic [15:0]               trigger_delay,
    input  logic [11:0]               sample_num,
    input  logic [CHAN*ADC_WIDTH-1:0] chan_data,
    output logic [CHAN-1:0]           TRIGGER,
    output logic [CHAN-1:0]           RD_REQUEST,
    output logic [DATA_WIDTH-1:0]     DOUT,
    output logic                      DOUT_VALID,
    input  logic                      DOUT_READY,
    output logic                      BUSY,
    output logic                      EVT_DONE
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DELAY,
        S_FREEZE,
        S_HDR,
        S_SEL,
        S_REQ,
        S_CAP,
        S_OUT,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic                    eos_p0;
    logic                    eos_p1;
    logic                    eos_rise;

    logic [CHAN-1:0]         mask_q;
    logic [15:0]             dly_cnt;
    logic [11:0]             smp_num_q;
    logic [11:0]             smp_cnt;
    logic [11:0]             evt_cnt;
    logic [3:0]              sel;
    logic [CHAN-1:0]         sel_onehot;
    logic [ADC_WIDTH-1:0]    sel_data;
    logic [DATA_WIDTH-1:0]   hdr_word;
    logic                    out_hs;
    logic                    smp_last;

    // Lowest-index channel still frozen; callers only use it when v is nonzero.
    function automatic logic [3:0] lowest_set(input logic [CHAN-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = CHAN - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    assign eos_rise = eos_p0 & ~eos_p1;
    assign out_hs   = DOUT_VALID & DOUT_READY;
    assign smp_last = (smp_cnt == (smp_num_q - 12'd1));
    assign hdr_word = DATA_WIDTH'({4'hE, evt_cnt});

    // Decode the selected channel into a one-hot strobe and its sample slice.
    always_comb begin
        sel_onehot = '0;
        sel_data   = '0;
        for (int i = 0; i < CHAN; i++) begin
            if (sel == 4'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_data      = chan_data[i*ADC_WIDTH +: ADC_WIDTH];
            end
        end
    end

    // Two-stage EOS sampler feeding the rising-edge detector.
    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            eos_p0 <= 1'b0;
            eos_p1 <= 1'b0;
        end else begin
            eos_p0 <= EOS;
            eos_p1 <= eos_p0;
        end
    end

    // State register.
    always_ff @(posedge SYSCLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; EOS edges are only looked at while idle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (eos_rise) state_nxt = (trigger_delay != 16'd0) ? S_DELAY : S_FREEZE;
            S_DELAY:  if (dly_cnt == 16'd1) state_nxt = S_FREEZE;
            S_FREEZE: state_nxt = S_HDR;
            S_HDR:    if (out_hs) state_nxt = S_SEL;
            S_SEL:    state_nxt = ((TRIGGER == '0) || (smp_num_q == 12'd0)) ? S_DONE : S_REQ;
            S_REQ:    state_nxt = S_CAP;
            S_CAP:    state_nxt = S_OUT;
            S_OUT:    if (out_hs) state_nxt = smp_last ? S_SEL : S_REQ;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Event parameters captured at the EOS edge, delay countdown and channel pick.
    always_ff @(posedge SYSCLK) begin
        case (state)
            S_IDLE: begin
                if (eos_rise) begin
                    mask_q    <= chan_mask;
                    dly_cnt   <= trigger_delay;
                    smp_num_q <= sample_num;
                end
            end
            S_DELAY: dly_cnt <= dly_cnt - 16'd1;
            S_SEL:   sel     <= lowest_set(TRIGGER);
            default: ;
        endcase
    end

    // Freeze mask, output word register, sample counter and event counter.
    // TRIGGER is loaded on the edge that enters FREEZE so it rises D+1 cycles after EOS.
    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            TRIGGER    <= '0;
            DOUT       <= '0;
            DOUT_VALID <= 1'b0;
            smp_cnt    <= '0;
            evt_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    smp_cnt <= '0;
                    if (eos_rise && (trigger_delay == 16'd0)) TRIGGER <= chan_mask;
                end
                S_DELAY: begin
                    if (dly_cnt == 16'd1) TRIGGER <= mask_q;
                end
                S_FREEZE: begin
                    DOUT       <= hdr_word;
                    DOUT_VALID <= 1'b1;
                end
                S_HDR: begin
                    if (DOUT_READY) begin
                        DOUT_VALID <= 1'b0;
                        evt_cnt    <= evt_cnt + 12'd1;
                    end
                end
                S_SEL: begin
                    if (smp_num_q == 12'd0) TRIGGER <= '0;
                end
                S_CAP: begin
                    DOUT       <= {sel_data, sel};
                    DOUT_VALID <= 1'b1;
                end
                S_OUT: begin
                    if (DOUT_READY) begin
                        DOUT_VALID <= 1'b0;
                        if (smp_last) begin
                            TRIGGER <= TRIGGER & ~sel_onehot;
                            smp_cnt <= '0;
                        end else begin
                            smp_cnt <= smp_cnt + 12'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign RD_REQUEST = (state == S_REQ) ? sel_onehot : '0;
    assign EVT_DONE   = (state == S_DONE);
    assign BUSY       = (state != S_IDLE);

endmodule

// File: tb/tb_chan_readout_sched.sv
// Bench for chan_readout_sched: event-level reference model (expected word stream,
// freeze timing, done pulse) driven with random data, random backpressure and directed corners.
module tb_chan_readout_sched;

    localparam int CHAN = 8;
    localparam int AW   = 12;
    localparam int DW   = 16;

    logic              SYSCLK = 1'b0;
    logic              RST = 1'b1;
    logic              EOS = 1'b0;
    logic [CHAN-1:0]   chan_mask = '0;
    logic [15:0]       trigger_delay = '0;
    logic [11:0]       sample_num = '0;
    logic [CHAN*AW-1:0] chan_data = '0;
    logic [CHAN-1:0]   TRIGGER;
    logic [CHAN-1:0]   RD_REQUEST;
    logic [DW-1:0]     DOUT;
    logic              DOUT_VALID;
    logic              DOUT_READY = 1'b0;
    logic              BUSY;
    logic              EVT_DONE;

    chan_readout_sched #(.CHAN(CHAN), .ADC_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .SYSCLK(SYSCLK), .RST(RST), .EOS(EOS), .chan_mask(chan_mask),
        .trigger_delay(trigger_delay), .sample_num(sample_num), .chan_data(chan_data),
        .TRIGGER(TRIGGER), .RD_REQUEST(RD_REQUEST), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
        .DOUT_READY(DOUT_READY), .BUSY(BUSY), .EVT_DONE(EVT_DONE)
    );

    always #5 SYSCLK = ~SYSCLK;

    int          n_chk = 0;
    int          n_err = 0;
    logic [11:0] evt_model = '0;
    logic [11:0] samp [CHAN][16];
    int          req_cnt [CHAN];
    int          pend_ch = -1;
    int          pend_k  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample just after the edge; model the channel buffers:
    // a request seen now gets its sample on chan_data for the following cycle only.
    task automatic tick();
        @(posedge SYSCLK);
        #1;
        for (int i = 0; i < CHAN; i++) chan_data[i*AW +: AW] = 12'($urandom);
        if (pend_ch >= 0) begin
            chan_data[pend_ch*AW +: AW] = samp[pend_ch][pend_k % 16];
            pend_ch = -1;
        end
        for (int i = 0; i < CHAN; i++) begin
            if (RD_REQUEST[i]) begin
                pend_ch = i;
                pend_k  = req_cnt[i];
                req_cnt[i]++;
            end
        end
    endtask

    task automatic rand_samp();
        for (int i = 0; i < CHAN; i++)
            for (int k = 0; k < 16; k++) samp[i][k] = 12'($urandom);
    endtask

    function automatic int nth_set(input logic [CHAN-1:0] m, input int j);
        int cnt;
        cnt = 0;
        for (int i = 0; i < CHAN; i++) begin
            if (m[i]) begin
                if (cnt == j) return i;
                cnt++;
            end
        end
        return -1;
    endfunction

    // One full event. rmode: 0 ready always, 1 random ready, 2 hold ready low 7 cycles on first data word.
    task automatic run_event(input logic [CHAN-1:0] mask, input logic [15:0] dly,
                             input logic [11:0] n, input int rmode, input bit repulse);
        logic [15:0]     exp_q[$];
        logic [15:0]     got_q[$];
        logic [CHAN-1:0] exp_trig;
        logic [CHAN-1:0] trig_first;
        logic [15:0]     prev_dout;
        bit              hdr_done, hold_prev, post_hs, rdy, bp_done;
        int              c, c_trig, c_hdr, c_lasths, c_done, n_done, bp_left, words_data, ch;

        exp_q.push_back({4'hE, evt_model});
        if (n != 0)
            for (int i = 0; i < CHAN; i++)
                if (mask[i])
                    for (int k = 0; k < int'(n); k++) exp_q.push_back({samp[i][k], 4'(i)});

        for (int i = 0; i < CHAN; i++) req_cnt[i] = 0;
        pend_ch = -1;
        exp_trig = '0; trig_first = '0; prev_dout = '0;
        hdr_done = 0; hold_prev = 0; post_hs = 0; bp_done = 0;
        c_trig = -1; c_hdr = -1; c_lasths = -100; c_done = -100; n_done = 0;
        bp_left = 0; words_data = 0;

        chan_mask = mask; trigger_delay = dly; sample_num = n; EOS = 1'b1;
        tick();
        c = 0;
        chk("busy_at_edge", BUSY, 0);
        EOS = 1'b0;
        while (c < 3000) begin
            tick();
            c++;
            if (c == 1) begin
                chk("busy_rise", BUSY, 1);
                chan_mask = CHAN'($urandom); trigger_delay = 16'($urandom); sample_num = 12'($urandom);
            end
            if (repulse && c == 4) EOS = 1'b1;
            if (repulse && c == 6) EOS = 1'b0;
            if (c_trig < 0 && TRIGGER != '0) begin c_trig = c; trig_first = TRIGGER; end
            if (c_hdr < 0 && DOUT_VALID) c_hdr = c;
            if (RD_REQUEST != '0) begin
                chk("rdreq_onehot", $countones(RD_REQUEST), 1);
                chk("rdreq_vs_valid", DOUT_VALID, 0);
                chk("rdreq_after_hdr", hdr_done, 1);
            end
            if (hold_prev) begin
                chk("hold_valid", DOUT_VALID, 1);
                chk("hold_dout", DOUT, prev_dout);
            end
            if (post_hs) chk("trig_after_hs", TRIGGER, exp_trig);
            if (EVT_DONE) begin
                n_done++;
                c_done = c;
                chk("trig_at_done", TRIGGER, 0);
                chk("done_after_hs", c, c_lasths + 2);
            end
            if (!BUSY) break;

            case (rmode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    if (DOUT_VALID && hdr_done && words_data == 0 && !bp_done) begin
                        bp_left = 7;
                        bp_done = 1;
                    end
                    rdy = (bp_left == 0);
                    if (bp_left > 0) bp_left--;
                end
            endcase
            DOUT_READY = rdy;
            hold_prev  = DOUT_VALID && !rdy;
            prev_dout  = DOUT;
            post_hs    = 0;
            if (DOUT_VALID && rdy) begin
                got_q.push_back(DOUT);
                c_lasths = c;
                post_hs  = 1;
                if (!hdr_done) begin
                    hdr_done = 1;
                    exp_trig = mask;
                end else begin
                    words_data++;
                    if (n != 0 && (words_data % int'(n)) == 0) begin
                        ch = nth_set(mask, words_data / int'(n) - 1);
                        if (ch >= 0) exp_trig[ch] = 1'b0;
                    end
                end
            end
        end
        chk("evt_in_budget", (c < 3000), 1);
        if (mask != '0) begin
            chk("trig_time", c_trig, 1 + int'(dly));
            chk("trig_value", trig_first, mask);
        end else begin
            chk("trig_none", c_trig, -1);
        end
        chk("hdr_time", c_hdr, 2 + int'(dly));
        chk("evt_done_cnt", n_done, 1);
        chk("busy_fall", c, c_done + 1);
        chk("word_cnt", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk("word", got_q[i], exp_q[i]);
        evt_model = evt_model + 12'd1;
        for (int i = 0; i < 3; i++) tick();
        chk("idle_busy", BUSY, 0);
        chk("idle_valid", DOUT_VALID, 0);
    endtask

    // Reset while a data word sits in the output register waiting for ready.
    task automatic rst_mid_event();
        int hs_cnt;
        bit fired;
        hs_cnt = 0; fired = 0;
        rand_samp();
        for (int i = 0; i < CHAN; i++) req_cnt[i] = 0;
        pend_ch = -1;
        chan_mask = 8'h0F; trigger_delay = 16'd0; sample_num = 12'd4; EOS = 1'b1;
        DOUT_READY = 1'b1;
        tick();
        EOS = 1'b0;
        for (int c = 0; c < 200 && !fired; c++) begin
            tick();
            if (DOUT_VALID) begin
                if (hs_cnt == 2) fired = 1;
                else hs_cnt++;
            end
        end
        chk("rst_armed", fired, 1);
        DOUT_READY = 1'b0;
        RST = 1'b1;
        tick();
        chk("rst_trigger", TRIGGER, 0);
        chk("rst_rdreq", RD_REQUEST, 0);
        chk("rst_dout", DOUT, 0);
        chk("rst_valid", DOUT_VALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", EVT_DONE, 0);
        RST = 1'b0;
        DOUT_READY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_valid", DOUT_VALID, 0);
        end
        chk("post_rst_busy", BUSY, 0);
        evt_model = '0;
    endtask

    initial begin
        RST = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("reset_trigger", TRIGGER, 0);
        chk("reset_rdreq", RD_REQUEST, 0);
        chk("reset_dout", DOUT, 0);
        chk("reset_valid", DOUT_VALID, 0);
        chk("reset_busy", BUSY, 0);
        chk("reset_done", EVT_DONE, 0);
        RST = 1'b0;
        tick();

        // Basic event and its follow-up header.
        for (int k = 0; k < 16; k++) begin samp[0][k] = 12'h123; samp[2][k] = 12'hABC; end
        run_event(8'h05, 16'd0, 12'd2, 0, 0);
        rand_samp();
        run_event(8'h05, 16'd0, 12'd2, 0, 0);

        // Trigger delay, backpressure, empty mask, zero samples, EOS re-pulse.
        rand_samp();
        run_event(8'h3A, 16'd5, 12'd2, 0, 0);
        rand_samp();
        run_event(8'h82, 16'd2, 12'd3, 2, 0);
        run_event(8'h00, 16'd3, 12'd4, 0, 0);
        run_event(8'hFF, 16'd1, 12'd0, 0, 0);
        rand_samp();
        run_event(8'h11, 16'd0, 12'd3, 0, 1);

        // Reset in the middle of the data phase, then a fresh event.
        rst_mid_event();
        rand_samp();
        run_event(8'h06, 16'd0, 12'd1, 0, 0);

        // Random events with random backpressure.
        for (int e = 0; e < 12; e++) begin
            rand_samp();
            run_event(CHAN'($urandom), 16'($urandom_range(0, 6)), 12'($urandom_range(0, 5)),
                      1, bit'($urandom_range(0, 1)));
        end

        // Walk the event counter up to its wrap point.
        while (evt_model != 12'hFFF) run_event(8'h00, 16'd0, 12'd0, 0, 0);
        rand_samp();
        run_event(8'h41, 16'd0, 12'd2, 1, 0);
        rand_samp();
        run_event(8'h41, 16'd1, 12'd2, 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
